// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the serial sequence detector.
// Words enter over valid/ready and leave one bit per clock on x; a one-word hold buffer keeps words streaming back to back.
module seq_bit_serializer #(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         x,
  output logic         x_valid,
  output logic         word_start,
  output logic         word_done,
  output logic         busy
);

  localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e        state;
  state_e        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_n;
  logic [W-1:0]  hold;
  logic [W-1:0]  hold_n;
  logic          hold_full;
  logic          hold_full_n;

  logic          x_n;
  logic          x_valid_n;
  logic          word_start_n;
  logic          word_done_n;
  logic          busy_n;

  logic          free_c;
  logic          accept_c;

  // Shifter can take a new word when idle or while its last bit is on x.
  assign free_c   = (state == S_IDLE) || (cnt == CNT_LAST);
  assign accept_c = in_valid && !hold_full;
  assign in_ready = !hold_full;

  // State register, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      word_start <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      x          <= x_n;
      x_valid    <= x_valid_n;
      word_start <= word_start_n;
      word_done  <= word_done_n;
      busy       <= busy_n;
    end
  end

  // Next-state: held word has priority over a bypass load when the shifter frees up.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    if (free_c) begin
      if (hold_full) begin
        state_n     = S_SHIFT;
        cnt_n       = '0;
        shreg_n     = hold;
        hold_full_n = 1'b0;
      end else if (accept_c) begin
        state_n = S_SHIFT;
        cnt_n   = '0;
        shreg_n = in_data;
      end else begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    end else begin
      cnt_n   = cnt + CW'(1);
      shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (accept_c) begin
        hold_n      = in_data;
        hold_full_n = 1'b1;
      end
    end
  end

  // Outputs for the next cycle are derived from the next state so x and strobes stay aligned.
  always_comb begin
    x_n          = IDLE_BIT;
    x_valid_n    = 1'b0;
    word_start_n = 1'b0;
    word_done_n  = 1'b0;
    busy_n       = (state_n == S_SHIFT) || hold_full_n;
    if (state_n == S_SHIFT) begin
      x_n          = MSB_FIRST ? shreg_n[W-1] : shreg_n[0];
      x_valid_n    = 1'b1;
      word_start_n = (cnt_n == '0);
      word_done_n  = (cnt_n == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first, LSB-first and single-bit instances share one clock and reset.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst_n;

  logic [7:0] m_data;
  logic       m_valid, m_ready, m_x, m_xv, m_ws, m_wd, m_busy;
  logic [7:0] l_data;
  logic       l_valid, l_ready, l_x, l_xv, l_ws, l_wd, l_busy;
  logic [0:0] o_data;
  logic       o_valid, o_ready, o_x, o_xv, o_ws, o_wd, o_busy;

  int tests_run;
  int tests_failed;

  seq_bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
    .x(m_x), .x_valid(m_xv), .word_start(m_ws), .word_done(m_wd), .busy(m_busy)
  );

  seq_bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .x(l_x), .x_valid(l_xv), .word_start(l_ws), .word_done(l_wd), .busy(l_busy)
  );

  seq_bit_serializer #(.W(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_data(o_data), .in_valid(o_valid), .in_ready(o_ready),
    .x(o_x), .x_valid(o_xv), .word_start(o_ws), .word_done(o_wd), .busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({m_x, m_xv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_msb got %b want 000001", {m_x, m_xv, m_ws, m_wd, m_busy, m_ready});
    end
    tests_run++;
    if ({l_x, l_xv, l_ws, l_wd, l_busy, l_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_lsb got %b want 000001", {l_x, l_xv, l_ws, l_wd, l_busy, l_ready});
    end
    tests_run++;
    if ({o_x, o_xv, o_ws, o_wd, o_busy, o_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_w1 got %b want 000001", {o_x, o_xv, o_ws, o_wd, o_busy, o_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hA5;
    @(negedge clk);
    m_data  = w;
    m_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) m_valid = 1'b0;
      tests_run++;
      if ({m_x, m_xv, m_ws, m_wd} !== {w[7-i], 1'b1, i == 0, i == 7}) begin
        tests_failed++;
        $display("FAIL single_bit%0d got %b want %b", i, {m_x, m_xv, m_ws, m_wd},
                 {w[7-i], 1'b1, i == 0, i == 7});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({m_x, m_xv, m_busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_after got %b want 000", {m_x, m_xv, m_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic        exp_rdy;
    s = 16'hF00F;
    @(negedge clk);
    m_data  = 8'hF0;
    m_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rdy = !(i >= 1 && i <= 7);
      tests_run++;
      if ({m_x, m_xv, m_ready} !== {s[15-i], 1'b1, exp_rdy}) begin
        tests_failed++;
        $display("FAIL b2b_bit%0d got %b want %b", i, {m_x, m_xv, m_ready}, {s[15-i], 1'b1, exp_rdy});
      end
      if (i == 0) m_data = 8'h0F;
      if (i == 1) m_valid = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if ({m_xv, m_busy, m_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL b2b_after got %b want 001", {m_xv, m_busy, m_ready});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    @(negedge clk);
    l_data  = w;
    l_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) l_valid = 1'b0;
      tests_run++;
      if ({l_x, l_xv, l_ws, l_wd} !== {w[i], 1'b1, i == 0, i == 7}) begin
        tests_failed++;
        $display("FAIL lsb_bit%0d got %b want %b", i, {l_x, l_xv, l_ws, l_wd}, {w[i], 1'b1, i == 0, i == 7});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({l_x, l_xv, l_busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL lsb_after got %b want 000", {l_x, l_xv, l_busy});
    end
  endtask

  // Three words with the 101 target straddling the word0/word1 boundary, watched by a small detector model.
  task automatic test_lsb_stream();
    logic [7:0]  words [3];
    logic [23:0] got;
    logic [2:0]  sh;
    int          idx, nbits, gaps, match_at;
    bit          pend, seen;
    words    = '{8'h80, 8'h02, 8'h00};
    got      = '0;
    sh       = '0;
    idx      = 0;
    nbits    = 0;
    gaps     = 0;
    match_at = -1;
    seen     = 1'b0;
    @(negedge clk);
    l_data  = words[0];
    l_valid = 1'b1;
    pend    = l_valid && l_ready;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (l_xv) begin
        if (nbits < 24) got[nbits] = l_x;
        sh = {sh[1:0], l_x};
        nbits++;
        seen = 1'b1;
        if (nbits >= 3 && sh == 3'b101 && match_at < 0) match_at = nbits - 1;
      end else if (seen && nbits < 24) begin
        gaps++;
      end
      if (pend) begin
        idx++;
        if (idx < 3) l_data = words[idx];
        else l_valid = 1'b0;
      end
      pend = l_valid && l_ready;
    end
    tests_run++;
    if (nbits != 24 || gaps != 0) begin
      tests_failed++;
      $display("FAIL stream_len got bits=%0d gaps=%0d want bits=24 gaps=0", nbits, gaps);
    end
    tests_run++;
    if (got !== 24'h000280) begin
      tests_failed++;
      $display("FAIL stream_bits got %h want 000280", got);
    end
    tests_run++;
    if (match_at != 9) begin
      tests_failed++;
      $display("FAIL stream_match got %0d want 9", match_at);
    end
  endtask

  task automatic test_async_reset();
    int residual;
    residual = 0;
    @(negedge clk);
    m_data  = 8'hC3;
    m_valid = 1'b1;
    @(negedge clk);
    m_data = 8'h55;
    @(negedge clk);
    m_valid = 1'b0;
    tests_run++;
    if ({m_x, m_xv, m_busy, m_ready} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL arst_pre got %b want 1110", {m_x, m_xv, m_busy, m_ready});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_x, m_xv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL arst_now got %b want 000001", {m_x, m_xv, m_ws, m_wd, m_busy, m_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_xv || m_busy || !m_ready) residual++;
    end
    tests_run++;
    if (residual != 0) begin
      tests_failed++;
      $display("FAIL arst_residual got %0d active cycles want 0", residual);
    end
  endtask

  task automatic test_w1();
    logic [2:0] d;
    d = 3'b101;
    @(negedge clk);
    o_data  = d[2];
    o_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({o_x, o_xv, o_ws, o_wd, o_ready} !== {d[2-i], 4'b1111}) begin
        tests_failed++;
        $display("FAIL w1_bit%0d got %b want %b", i, {o_x, o_xv, o_ws, o_wd, o_ready}, {d[2-i], 4'b1111});
      end
      if (i < 2) o_data = d[1-i];
      else o_valid = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if ({o_xv, o_busy, o_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL w1_after got %b want 001", {o_xv, o_busy, o_ready});
    end
  endtask

  task automatic test_idle_gap();
    logic [7:0] w1, w2;
    logic       in_w1, in_w2, exp_x;
    logic [3:0] exp;
    w1 = 8'h81;
    w2 = 8'h7E;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        in_w1 = (c >= 1 && c <= 8);
        in_w2 = (c >= 12 && c <= 19);
        exp_x = in_w1 ? w1[8-c] : (in_w2 ? w2[19-c] : 1'b0);
        exp   = {exp_x, in_w1 || in_w2, c == 1 || c == 12, c == 8 || c == 19};
        tests_run++;
        if ({m_x, m_xv, m_ws, m_wd} !== exp) begin
          tests_failed++;
          $display("FAIL gap_cycle%0d got %b want %b", c, {m_x, m_xv, m_ws, m_wd}, exp);
        end
      end
      m_valid = (c == 0 || c == 11);
      m_data  = (c < 11) ? w1 : w2;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    m_data       = '0;
    m_valid      = 1'b0;
    l_data       = '0;
    l_valid      = 1'b0;
    o_data       = '0;
    o_valid      = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_lsb_stream();
    test_async_reset();
    test_w1();
    test_idle_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
